// File: rtl/nv_fifo_ctrl_16x14.sv
// rtl/nv_fifo_ctrl_16x14.sv - 16x14 FIFO controller for a 2-stage-read RAM with a 3-entry output skid buffer
// Optional status outputs (fifo_count, fifo_idle) are built when NV_FIFO_CTRL_STATUS_EN is defined.
module nv_fifo_ctrl_16x14 #(
    parameter int RD_SKID_DEPTH = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_pvld,
    output logic        wr_prdy,
    input  logic [13:0] wr_pd,
    output logic        rd_pvld,
    input  logic        rd_prdy,
    output logic [13:0] rd_pd,
    output logic [3:0]  ram_wa,
    output logic        ram_we,
    output logic [13:0] ram_di,
    output logic [3:0]  ram_ra,
    output logic        ram_re,
    output logic        ram_ore,
    input  logic [13:0] ram_dout,
    input  logic [31:0] pwrbus_ram_pd,
    output logic [31:0] ram_pwrbus_ram_pd
`ifdef NV_FIFO_CTRL_STATUS_EN
    ,
    output logic [4:0]  fifo_count,
    output logic        fifo_idle
`endif
);

    localparam logic [2:0] SKID_DEPTH = 3'(RD_SKID_DEPTH);

    logic [3:0]  wptr;
    logic [3:0]  rptr;
    logic [4:0]  count;
    logic [1:0]  inflight;
    logic [1:0]  skid_count;
    logic        ore_q;
    logic        cap_q;
    logic [13:0] skid_mem [3];

    logic        wr_accept;
    logic        rd_issue;
    logic        rd_pop;
    logic [2:0]  slots_used;
    logic [1:0]  cap_idx;

    // Write side: ready only depends on occupancy; nothing is accepted while in reset.
    assign wr_prdy   = rst | ~count[4];
    assign wr_accept = wr_pvld & ~count[4] & ~rst;
    assign ram_we    = wr_accept;
    assign ram_wa    = wptr;
    assign ram_di    = wr_pd;

    assign rd_pvld = ~rst & (skid_count != 2'd0);
    assign rd_pd   = skid_mem[0];
    assign rd_pop  = rd_pvld & rd_prdy;

    // A head popping this cycle frees its slot, which keeps one read per cycle while streaming.
    assign slots_used = {1'b0, inflight} + {1'b0, skid_count} - {2'b00, rd_pop};
    assign rd_issue   = ~rst & (count != 5'd0) & (slots_used < SKID_DEPTH);
    assign ram_re     = rd_issue;
    assign ram_ra     = rptr;
    assign ram_ore    = ore_q & ~rst;

    assign cap_idx = skid_count - {1'b0, rd_pop};

    assign ram_pwrbus_ram_pd = pwrbus_ram_pd;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= 4'd0;
            rptr       <= 4'd0;
            count      <= 5'd0;
            inflight   <= 2'd0;
            skid_count <= 2'd0;
            ore_q      <= 1'b0;
            cap_q      <= 1'b0;
        end else begin
            if (wr_accept) begin
                wptr <= wptr + 4'd1;
            end
            if (rd_issue) begin
                rptr <= rptr + 4'd1;
            end
            count      <= count + {4'd0, wr_accept} - {4'd0, rd_issue};
            inflight   <= inflight + {1'b0, rd_issue} - {1'b0, cap_q};
            skid_count <= skid_count + {1'b0, cap_q} - {1'b0, rd_pop};
            ore_q      <= rd_issue;
            cap_q      <= ore_q;
        end
    end

    // Skid storage is a shift queue with the head at index 0; contents need no reset.
    always_ff @(posedge clk) begin
        if (rd_pop) begin
            skid_mem[0] <= skid_mem[1];
            skid_mem[1] <= skid_mem[2];
        end
        if (cap_q) begin
            skid_mem[cap_idx] <= ram_dout;
        end
    end

`ifdef NV_FIFO_CTRL_STATUS_EN
    logic [4:0] total_nxt;

    assign total_nxt = count + {4'd0, wr_accept} + {3'd0, inflight} + {3'd0, skid_count}
                     - {4'd0, rd_pop};

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_count <= 5'd0;
            fifo_idle  <= 1'b1;
        end else begin
            fifo_count <= total_nxt;
            fifo_idle  <= (total_nxt == 5'd0) & ~wr_accept;
        end
    end
`endif

endmodule

// File: tb/tb_nv_fifo_ctrl_16x14.sv
// tb/tb_nv_fifo_ctrl_16x14.sv - scoreboard bench for nv_fifo_ctrl_16x14 with a behavioural 2-stage RAM
module tb_nv_fifo_ctrl_16x14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_pvld = 1'b0;
    logic        wr_prdy;
    logic [13:0] wr_pd = 14'd0;
    logic        rd_pvld;
    logic        rd_prdy = 1'b0;
    logic [13:0] rd_pd;
    logic [3:0]  ram_wa;
    logic        ram_we;
    logic [13:0] ram_di;
    logic [3:0]  ram_ra;
    logic        ram_re;
    logic        ram_ore;
    logic [13:0] ram_dout;
    logic [31:0] pwrbus_ram_pd = 32'd0;
    logic [31:0] ram_pwrbus_ram_pd;
`ifdef NV_FIFO_CTRL_STATUS_EN
    logic [4:0]  fifo_count;
    logic        fifo_idle;
`endif

    nv_fifo_ctrl_16x14 #(.RD_SKID_DEPTH(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .wr_pvld           (wr_pvld),
        .wr_prdy           (wr_prdy),
        .wr_pd             (wr_pd),
        .rd_pvld           (rd_pvld),
        .rd_prdy           (rd_prdy),
        .rd_pd             (rd_pd),
        .ram_wa            (ram_wa),
        .ram_we            (ram_we),
        .ram_di            (ram_di),
        .ram_ra            (ram_ra),
        .ram_re            (ram_re),
        .ram_ore           (ram_ore),
        .ram_dout          (ram_dout),
        .pwrbus_ram_pd     (pwrbus_ram_pd),
        .ram_pwrbus_ram_pd (ram_pwrbus_ram_pd)
`ifdef NV_FIFO_CTRL_STATUS_EN
        ,
        .fifo_count        (fifo_count),
        .fifo_idle         (fifo_idle)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural RAM: address latched on re, output register loaded on ore.
    logic [13:0] mem [16];
    logic [3:0]  ra_q;
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wa] <= ram_di;
        if (ram_re) ra_q <= ram_ra;
        if (ram_ore) ram_dout <= mem[ra_q];
    end

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_pops = 0;
    logic [13:0] exp_q [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: reference model is an ordered queue of accepted words, emptied by reset.
    logic        prev_stall = 1'b0;
    logic [13:0] prev_pd = 14'd0;
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_pvld", 32'(rd_pvld), 32'd1);
                chk("stall_pd", 32'(rd_pd), 32'(prev_pd));
            end
            if (rd_pvld && rd_prdy) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_read: got 0x%0h, expected no word", rd_pd);
                end else begin
                    chk("rd_pd", 32'(rd_pd), 32'(exp_q.pop_front()));
                    n_pops++;
                end
            end
            if (wr_pvld && wr_prdy) exp_q.push_back(wr_pd);
            prev_stall = rd_pvld && !rd_prdy;
            prev_pd    = rd_pd;
        end
    end

    task automatic write_word(input logic [13:0] d);
        int w = 0;
        wr_pvld = 1'b1;
        wr_pd   = d;
        @(negedge clk);
        while (!wr_prdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!wr_prdy) chk("write_timeout", 32'(wr_prdy), 32'd1);
        @(posedge clk);
        #1;
        wr_pvld = 1'b0;
    endtask

    task automatic drain(input string name);
        int w = 0;
        wr_pvld = 1'b0;
        rd_prdy = 1'b1;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk({name, "_idle"}, 32'(rd_pvld), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic latency_test(input logic [13:0] d);
        wr_pvld = 1'b1;
        wr_pd   = d;
        rd_prdy = 1'b1;
        @(posedge clk);
        #1;
        wr_pvld = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("lat_pvld_c%0d", k), 32'(rd_pvld), 32'(k == 4));
            if (k == 4) chk("lat_pd", 32'(rd_pd), 32'(d));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_checks(input string name);
        chk({name, "_rd_pvld"}, 32'(rd_pvld), 32'd0);
        chk({name, "_ram_we"}, 32'(ram_we), 32'd0);
        chk({name, "_ram_re"}, 32'(ram_re), 32'd0);
        chk({name, "_ram_ore"}, 32'(ram_ore), 32'd0);
        chk({name, "_wr_prdy"}, 32'(wr_prdy), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0;
        int acc;
        int outs;
        int gaps;
        int last_c;
        int first_c;
        int cyc;

        pwrbus_ram_pd = $urandom;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        idle_checks("in_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        idle_checks("post_reset");
        chk("pwrbus", ram_pwrbus_ram_pd, pwrbus_ram_pd);
        @(posedge clk);
        #1;

        // Single word latency
        latency_test(14'h1ABC);
        drain("single");

        // Fill to full with the reader stalled
        rd_prdy = 1'b0;
        for (int i = 0; i < 19; i++) write_word(14'(i));
        @(negedge clk);
        chk("full_wr_prdy", 32'(wr_prdy), 32'd0);
        chk("full_head", 32'(rd_pd), 32'd0);
        @(posedge clk);
        #1;
        p0 = n_pops;
        drain("fill");
        chk("fill_pops", 32'(n_pops - p0), 32'd19);

        // Streaming at full rate
        acc = 0; outs = 0; gaps = 0; last_c = -1; first_c = -1;
        p0 = n_pops;
        for (int c = 0; c < 100; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = 14'(16'h0100 + c);
            rd_prdy = 1'b1;
            @(negedge clk);
            if (wr_prdy) acc++;
            if (rd_pvld) begin
                if (first_c < 0) first_c = c;
                if (last_c >= 0 && c != last_c + 1) gaps++;
                last_c = c;
                outs++;
            end
            @(posedge clk);
            #1;
        end
        wr_pvld = 1'b0;
        chk("stream_accepts", 32'(acc), 32'd100);
        chk("stream_outs", 32'(outs), 32'd96);
        chk("stream_first", 32'(first_c), 32'd4);
        chk("stream_gaps", 32'(gaps), 32'd0);
        drain("stream");
        chk("stream_pops", 32'(n_pops - p0), 32'd100);

        // Backpressure: reader ready toggles every cycle
        acc = 0;
        p0 = n_pops;
        for (int c = 0; c < 60; c++) begin
            wr_pvld = 1'b1;
            wr_pd   = 14'(16'h2000 + c);
            rd_prdy = c[0];
            @(negedge clk);
            if (wr_prdy) acc++;
            @(posedge clk);
            #1;
        end
        wr_pvld = 1'b0;
        drain("bp");
        chk("bp_no_loss", 32'(n_pops - p0), 32'(acc));

        // Pointer wrap with random traffic
        acc = 0;
        cyc = 0;
        p0 = n_pops;
        while (acc < 40 && cyc < 400) begin
            wr_pvld = ($urandom_range(3) != 0);
            wr_pd   = 14'($urandom);
            rd_prdy = $urandom_range(1);
            @(negedge clk);
            if (wr_pvld && wr_prdy) acc++;
            @(posedge clk);
            #1;
            cyc++;
        end
        wr_pvld = 1'b0;
        chk("wrap_accepts", 32'(acc), 32'd40);
        drain("wrap");
        chk("wrap_pops", 32'(n_pops - p0), 32'd40);

        // Mid-operation reset with words queued
        rd_prdy = 1'b0;
        for (int i = 0; i < 10; i++) write_word(14'(16'h3000 + i));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_rd_pvld", 32'(rd_pvld), 32'd0);
        chk("rst_mid_wr_prdy", 32'(wr_prdy), 32'd1);
        @(posedge clk);
        #1;
        latency_test(14'h0005);
        drain("after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/nv_fifo_ctrl_16x14.md
NV_FIFO_CTRL_16X14 -- requirements
Module: nv_fifo_ctrl_16x14

Interface
REQ-001 SHALL have parameter RD_SKID_DEPTH, default 3; number of output skid entries, legal value 3 only.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port wr_pvld  input  1  write valid.
REQ-005 SHALL have port wr_prdy  output  1  write ready.
REQ-006 SHALL have port wr_pd  input  14  write payload.
REQ-007 SHALL have port rd_pvld  output  1  read valid.
REQ-008 SHALL have port rd_prdy  input  1  read ready.
REQ-009 SHALL have port rd_pd  output  14  read payload.
REQ-010 SHALL have port ram_wa  output  4  RAM write address.
REQ-011 SHALL have port ram_we  output  1  RAM write enable.
REQ-012 SHALL have port ram_di  output  14  RAM write data.
REQ-013 SHALL have port ram_ra  output  4  RAM read address.
REQ-014 SHALL have port ram_re  output  1  RAM read-address-latch enable.
REQ-015 SHALL have port ram_ore  output  1  RAM output-register enable.
REQ-016 SHALL have port ram_dout  input  14  RAM registered read data.
REQ-017 SHALL have port pwrbus_ram_pd  input  32  RAM power bus, passed through unchanged.
REQ-018 SHALL have port ram_pwrbus_ram_pd  output  32  copy of pwrbus_ram_pd.

Function
REQ-019 SHALL drive a 16x14 RAM with a 2-stage read: ra latched when re=1, dout register loaded when ore=1.
REQ-020 SHALL keep a 4-bit wptr, a 4-bit rptr (both wrap 15->0) and a 5-bit entry count, range 0..16.
REQ-021 SHALL assert wr_prdy = (count < 16), combinationally, with no dependence on wr_pvld.
REQ-022 SHALL assert ram_we = wr_pvld & wr_prdy, with ram_wa = wptr and ram_di = wr_pd in the same cycle.
REQ-023 SHALL issue a read (ram_re=1, ram_ra=rptr) when count > 0 and (inflight + skid_count) < 3; on issue, count decrements and rptr increments.
REQ-024 SHALL assert ram_ore exactly one cycle after each ram_re, and capture ram_dout into the skid buffer exactly one cycle after that ram_ore.
REQ-025 SHALL track inflight (0..2) as the number of reads issued but not yet captured into the skid buffer.
REQ-026 SHALL make the skid buffer a 3-entry in-order buffer; rd_pvld = (skid_count > 0), rd_pd = head entry; the head pops on rd_pvld & rd_prdy.
REQ-027 SHALL achieve 4-cycle latency: a write accepted in cycle 0 on an empty block gives rd_pvld=1 in cycle 4.
REQ-028 SHALL sustain one write and one read per cycle when rd_prdy is held at 1.
REQ-029 SHALL, on a simultaneous write and read issue, change count by +1-1 = 0.
REQ-030 SHALL never overflow: the skid buffer holds at most 3 entries whatever the rd_prdy pattern.
REQ-031 SHALL hold rd_pd stable while rd_pvld=1 and rd_prdy=0.
REQ-032 SHALL never issue a read of an entry in the same cycle that the entry is written.

Reset
REQ-033 SHALL, on a clk edge with rst=1, clear wptr, rptr, count, inflight, skid_count and the ore pipeline to 0.
REQ-034 SHALL hold these outputs during and after reset until the next write: rd_pvld=0, ram_we=0, ram_re=0, ram_ore=0, wr_prdy=1.
REQ-035 SHALL, on rst asserted mid-operation, discard all queued and in-flight data; skid contents are don't-care while rd_pvld=0.

Configuration
REQ-036 SHALL, when macro NV_FIFO_CTRL_STATUS_EN is defined, add two registered outputs, both reset to their empty values:
- fifo_count[4:0] = count + inflight + skid_count (total occupancy, 0..19, reset 0);
- fifo_idle = 1 when fifo_count is 0 and no write is accepted this cycle (reset 1).
REQ-037 SHALL, without NV_FIFO_CTRL_STATUS_EN, omit both ports and their logic.

Verification
REQ-038 SHALL cover single word: write 0x1ABC in cycle 0 with rd_prdy=1 -> rd_pvld=1 and rd_pd=0x1ABC in cycle 4 only.
REQ-039 SHALL cover fill to full: rd_prdy=0, write 0x0000..0x0012 (19 words) -> wr_prdy=0 after the 19th accept; drain gives 19 words in order.
REQ-040 SHALL cover streaming: wr_pvld=1 and rd_prdy=1 for 100 cycles with an incrementing payload -> 96 words out in order, no gaps after the first.
REQ-041 SHALL cover backpressure: rd_prdy toggles 1/0 every cycle during streaming -> no loss or duplication, rd_pd stable while stalled.
REQ-042 SHALL cover pointer wrap: 40 words through with random rd_prdy -> correct order across the ptr 15->0 wrap.
REQ-043 SHALL cover mid-operation reset: rst=1 for 1 cycle with 10 words queued -> next cycle rd_pvld=0 and wr_prdy=1; a later write 0x0005 gives rd_pd=0x0005 after 4 cycles.
